// File: rtl/rift2_wb_pkg.sv
// Shared types and constants for the Rift2 Wishbone/debug arbiter.
package rift2_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_WB  = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int          WD_W         = 16;

endpackage

// File: rtl/rift2_rr_arb2.sv
// Two-way round-robin pick; the loser of the previous grant wins the next tie.
module rift2_rr_arb2
    import rift2_wb_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_srst,
    input  logic   i_en,
    input  logic   i_req_wb,
    input  logic   i_req_dbg,
    output logic   o_grant,
    output owner_t o_owner
);

    owner_t r_last_owner;

    always_comb begin
        o_grant = i_req_wb | i_req_dbg;
        if (i_req_wb && i_req_dbg) begin
            o_owner = (r_last_owner == OWN_DBG) ? OWN_WB : OWN_DBG;
        end else if (i_req_wb) begin
            o_owner = OWN_WB;
        end else begin
            o_owner = OWN_DBG;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_last_owner <= OWN_DBG;
        end else if (i_en && o_grant) begin
            r_last_owner <= o_owner;
        end
    end

endmodule

// File: rtl/rift2_wb_arbiter.sv
// Shares the internal target port between the Caravel Wishbone slave and the
// debug requester, one transaction at a time, with a watchdog on the target.
module rift2_wb_arbiter
    import rift2_wb_pkg::*;
#(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter int              TO_CYC   = 255,
    parameter logic [DW-1:0]   ERR_DATA = DW'(ERR_DATA_DEF)
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [DW/8-1:0]   wbs_sel_i,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DW-1:0]     wbs_dat_o,
    input  logic              dbg_valid_i,
    input  logic              dbg_we_i,
    input  logic [AW-1:0]     dbg_adr_i,
    input  logic [DW-1:0]     dbg_dat_i,
    output logic              dbg_done_o,
    output logic [DW-1:0]     dbg_rdata_o,
    output logic              dbg_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [DW/8-1:0]   mem_sel_o,
    output logic [AW-1:0]     mem_adr_o,
    output logic [DW-1:0]     mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DW-1:0]     mem_rdata_i,
    output logic              timeout_o
);

    localparam logic [WD_W-1:0] TO_LIM = WD_W'(TO_CYC);

    state_t            r_state;
    owner_t            r_owner;
    logic [WD_W-1:0]   r_wd;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [DW/8-1:0]   r_mem_sel;
    logic [AW-1:0]     r_mem_adr;
    logic [DW-1:0]     r_mem_wdata;
    logic              r_wbs_ack;
    logic [DW-1:0]     r_wbs_dat;
    logic              r_dbg_done;
    logic [DW-1:0]     r_dbg_rdata;
    logic              r_dbg_err;
    logic              r_timeout;

    logic              w_grant;
    owner_t            w_owner;
    logic              w_finish;
    logic              w_to_hit;
    logic [DW-1:0]     w_resp_data;

    rift2_rr_arb2 u_arb (
        .i_clk     (wb_clk_i),
        .i_srst    (wb_rst_i),
        .i_en      (r_state == ST_IDLE),
        .i_req_wb  (wbs_cyc_i & wbs_stb_i),
        .i_req_dbg (dbg_valid_i),
        .o_grant   (w_grant),
        .o_owner   (w_owner)
    );

    // An ack arriving on the watchdog's last cycle still counts as a normal completion.
    always_comb begin
        w_to_hit    = !mem_ack_i && (r_wd >= TO_LIM);
        w_finish    = mem_ack_i || w_to_hit;
        w_resp_data = w_to_hit ? ERR_DATA : (r_mem_we ? '0 : mem_rdata_i);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_WB;
            r_wd        <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_sel   <= '0;
            r_mem_adr   <= '0;
            r_mem_wdata <= '0;
            r_wbs_ack   <= 1'b0;
            r_wbs_dat   <= '0;
            r_dbg_done  <= 1'b0;
            r_dbg_rdata <= '0;
            r_dbg_err   <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_wbs_ack  <= 1'b0;
            r_dbg_done <= 1'b0;
            r_dbg_err  <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state   <= ST_BUSY;
                        r_owner   <= w_owner;
                        r_wd      <= WD_W'(1);
                        r_mem_req <= 1'b1;
                        if (w_owner == OWN_WB) begin
                            r_mem_we    <= wbs_we_i;
                            r_mem_sel   <= wbs_sel_i;
                            r_mem_adr   <= wbs_adr_i;
                            r_mem_wdata <= wbs_dat_i;
                        end else begin
                            r_mem_we    <= dbg_we_i;
                            r_mem_sel   <= '1;
                            r_mem_adr   <= dbg_adr_i;
                            r_mem_wdata <= dbg_dat_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_finish) begin
                        r_state   <= ST_RESP;
                        r_mem_req <= 1'b0;
                        r_timeout <= w_to_hit;
                        if (r_owner == OWN_WB) begin
                            r_wbs_dat <= w_resp_data;
                            // A master that dropped cyc has abandoned the cycle.
                            r_wbs_ack <= wbs_cyc_i;
                        end else begin
                            r_dbg_rdata <= w_resp_data;
                            r_dbg_done  <= 1'b1;
                            r_dbg_err   <= w_to_hit;
                        end
                    end else if (r_wd != '1) begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wd    <= '0;
                end
            endcase
        end
    end

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_sel_o   = r_mem_sel;
    assign mem_adr_o   = r_mem_adr;
    assign mem_wdata_o = r_mem_wdata;
    assign wbs_ack_o   = r_wbs_ack;
    assign wbs_dat_o   = r_wbs_dat;
    assign dbg_done_o  = r_dbg_done;
    assign dbg_rdata_o = r_dbg_rdata;
    assign dbg_err_o   = r_dbg_err;
    assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_rift2_wb_arbiter.sv
// Directed bench for rift2_wb_arbiter: transaction-level reference model with a
// per-cycle output compare, plus literal expectations for the headline scenarios.
module tb_rift2_wb_arbiter;

    localparam int          AW   = 32;
    localparam int          DW   = 32;
    localparam int          T    = 8;
    localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [3:0]    wbs_sel = '0;
    logic [31:0]   wbs_adr = '0, wbs_dat = '0;
    logic          dbg_valid = 1'b0, dbg_we = 1'b0;
    logic [31:0]   dbg_adr = '0, dbg_dat = '0;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;

    logic          wbs_ack_o, dbg_done_o, dbg_err_o, mem_req_o, mem_we_o, timeout_o;
    logic [31:0]   wbs_dat_o, dbg_rdata_o, mem_adr_o, mem_wdata_o;
    logic [3:0]    mem_sel_o;

    rift2_wb_arbiter #(.AW(AW), .DW(DW), .TO_CYC(T), .ERR_DATA(ERRV)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(wbs_cyc), .wbs_stb_i(wbs_stb), .wbs_we_i(wbs_we),
        .wbs_sel_i(wbs_sel), .wbs_adr_i(wbs_adr), .wbs_dat_i(wbs_dat),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .dbg_valid_i(dbg_valid), .dbg_we_i(dbg_we), .dbg_adr_i(dbg_adr), .dbg_dat_i(dbg_dat),
        .dbg_done_o(dbg_done_o), .dbg_rdata_o(dbg_rdata_o), .dbg_err_o(dbg_err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o),
        .mem_adr_o(mem_adr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a granted transaction completes on ack or at its deadline
    // (grant cycle + T); the port is free again two cycles after completion.
    int          cyc = 0;
    bit          m_busy = 0, m_dbg = 0, m_last_dbg = 1, hit;
    int          m_deadline = 0, m_free_at = 0;
    logic        e_req = 0, e_we = 0, e_wbs_ack = 0, e_done = 0, e_err = 0, e_to = 0;
    logic [3:0]  e_sel = '0;
    logic [31:0] e_adr = '0, e_wdata = '0, e_wbs_dat = '0, e_rdata = '0, rdat;
    bit          wbv, dv, pick_dbg;

    initial forever begin
        @(posedge clk);
        if (rst) begin
            {e_req, e_we, e_wbs_ack, e_done, e_err, e_to} = '0;
            e_sel = '0; e_adr = '0; e_wdata = '0; e_wbs_dat = '0; e_rdata = '0;
            m_busy = 0; m_last_dbg = 1; m_free_at = cyc + 1;
        end else begin
            e_wbs_ack = 0; e_done = 0; e_err = 0; e_to = 0;
            if (m_busy) begin
                if (mem_ack || cyc == m_deadline) begin
                    hit  = !mem_ack;
                    rdat = hit ? ERRV : (e_we ? 32'h0 : mem_rdata);
                    e_req = 0; m_busy = 0; m_free_at = cyc + 2; e_to = hit;
                    if (m_dbg) begin
                        e_done = 1; e_err = hit; e_rdata = rdat;
                    end else begin
                        e_wbs_dat = rdat; e_wbs_ack = wbs_cyc;
                    end
                end
            end else if (cyc >= m_free_at) begin
                wbv = wbs_cyc && wbs_stb;
                dv  = dbg_valid;
                if (wbv || dv) begin
                    pick_dbg   = (wbv && dv) ? !m_last_dbg : dv;
                    m_last_dbg = pick_dbg;
                    m_dbg      = pick_dbg;
                    m_busy     = 1;
                    m_deadline = cyc + T;
                    e_req      = 1;
                    e_we       = pick_dbg ? dbg_we  : wbs_we;
                    e_sel      = pick_dbg ? 4'hF    : wbs_sel;
                    e_adr      = pick_dbg ? dbg_adr : wbs_adr;
                    e_wdata    = pick_dbg ? dbg_dat : wbs_dat;
                end
            end
        end
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        chk("mem_req",   32'(mem_req_o),   32'(e_req));
        chk("mem_we",    32'(mem_we_o),    32'(e_we));
        chk("mem_sel",   32'(mem_sel_o),   32'(e_sel));
        chk("mem_adr",   mem_adr_o,        e_adr);
        chk("mem_wdata", mem_wdata_o,      e_wdata);
        chk("wbs_ack",   32'(wbs_ack_o),   32'(e_wbs_ack));
        chk("wbs_dat",   wbs_dat_o,        e_wbs_dat);
        chk("dbg_done",  32'(dbg_done_o),  32'(e_done));
        chk("dbg_rdata", dbg_rdata_o,      e_rdata);
        chk("dbg_err",   32'(dbg_err_o),   32'(e_err));
        chk("timeout",   32'(timeout_o),   32'(e_to));
    end

    // Target: acks in the (t_delay+1)-th cycle of a request; t_delay < 0 never acks.
    int          t_delay = 0, t_k = 0;
    bit          t_stray = 0;
    logic [31:0] t_rdata = '0;

    initial forever begin
        @(negedge clk);
        if (mem_req_o === 1'b1) t_k++; else t_k = 0;
        mem_ack   = t_stray || (mem_req_o === 1'b1 && t_delay >= 0 && t_k == t_delay + 1);
        mem_rdata = t_rdata;
    end

    // Monitor: running totals and a log of grants (first cycle of each request).
    int          mcyc = 0, m_reqcyc = 0, m_acks = 0, m_dones = 0, m_tos = 0, m_to_cyc = 0, n_gr = 0;
    int          g_cyc [64];
    logic [31:0] g_adr [64];
    logic        prev_req = 1'b0;

    initial forever begin
        @(negedge clk);
        mcyc++;
        if (mem_req_o === 1'b1) m_reqcyc++;
        if (mem_req_o === 1'b1 && prev_req !== 1'b1) begin
            if (n_gr < 64) begin
                g_cyc[n_gr] = mcyc;
                g_adr[n_gr] = mem_adr_o;
            end
            n_gr++;
        end
        prev_req = mem_req_o;
        if (wbs_ack_o === 1'b1)  m_acks++;
        if (dbg_done_o === 1'b1) m_dones++;
        if (timeout_o === 1'b1) begin
            m_tos++;
            m_to_cyc = mcyc;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wb_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          output logic [31:0] rd);
        bit got = 0;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = we; wbs_sel = 4'hF; wbs_adr = adr; wbs_dat = dat;
        rd = '0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (wbs_ack_o === 1'b1) begin
                got = 1;
                rd  = wbs_dat_o;
            end
        end
        wbs_cyc = 0; wbs_stb = 0;
        chk("wb_ack_seen", 32'(got), 32'd1);
        $display("WB  %s adr=%08h data=%08h", we ? "WR" : "RD", adr, we ? dat : rd);
    endtask

    task automatic dbg_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           output logic [31:0] rd, output logic err);
        bit got = 0;
        dbg_valid = 1; dbg_we = we; dbg_adr = adr; dbg_dat = dat;
        rd = '0; err = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            step();
            if (dbg_done_o === 1'b1) begin
                got = 1;
                rd  = dbg_rdata_o;
                err = dbg_err_o;
            end
        end
        dbg_valid = 0;
        chk("dbg_done_seen", 32'(got), 32'd1);
        $display("DBG %s adr=%08h data=%08h err=%0d", we ? "WR" : "RD", adr, we ? dat : rd, err);
    endtask

    logic [31:0] rd;
    logic        err;
    int          s_req, s_ack, s_done, s_to, g0;

    initial begin
        // Reset state
        step(); step();
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_wbs_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_wbs_dat", wbs_dat_o, 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        rst = 0;
        step();

        // WB read, target acks two cycles after the request rises
        t_delay = 2; t_rdata = 32'h1234_5678;
        s_req = m_reqcyc; s_ack = m_acks;
        wb_txn(1'b0, 32'h3000_0010, 32'h0, rd);
        step(); step();
        chk("t1_rdata", rd, 32'h1234_5678);
        chk("t1_req_cycles", 32'(m_reqcyc - s_req), 32'd3);
        chk("t1_ack_pulses", 32'(m_acks - s_ack), 32'd1);

        // Both requesting from reset, zero-wait target: WB, DBG, WB, DBG at 3-cycle pitch
        rst = 1; step();
        rst = 0; t_delay = 0; t_rdata = 32'h0000_00C3;
        g0 = n_gr;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_sel = 4'hF; wbs_adr = 32'h0000_00A0;
        dbg_valid = 1; dbg_we = 0; dbg_adr = 32'h0000_00B0;
        repeat (12) step();
        wbs_cyc = 0; wbs_stb = 0; dbg_valid = 0;
        repeat (3) step();
        chk("t2_grants", 32'(n_gr - g0), 32'd4);
        chk("t2_own0", g_adr[g0],     32'h0000_00A0);
        chk("t2_own1", g_adr[g0 + 1], 32'h0000_00B0);
        chk("t2_own2", g_adr[g0 + 2], 32'h0000_00A0);
        chk("t2_own3", g_adr[g0 + 3], 32'h0000_00B0);
        for (int i = 1; i < 4; i++) chk("t2_pitch", 32'(g_cyc[g0 + i] - g_cyc[g0 + i - 1]), 32'd3);
        $display("RR  4 grants, pitch %0d cycles", g_cyc[g0 + 1] - g_cyc[g0]);

        // Debug write, target never acks: watchdog terminates it
        t_delay = -1;
        s_to = m_tos;
        dbg_txn(1'b1, 32'h0000_0040, 32'h0000_0077, rd, err);
        step();
        chk("t3_rdata", rd, 32'hDEAD_BEEF);
        chk("t3_err", 32'(err), 32'd1);
        chk("t3_to_pulses", 32'(m_tos - s_to), 32'd1);
        chk("t3_to_delay", 32'(m_to_cyc - g_cyc[n_gr - 1]), 32'd8);

        // WB write aborted while BUSY: request held to ack, no Wishbone ack
        t_delay = 3;
        s_req = m_reqcyc; s_ack = m_acks;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 1; wbs_adr = 32'h0000_0050; wbs_dat = 32'h0000_1111;
        step(); step();
        wbs_cyc = 0; wbs_stb = 0;
        repeat (8) step();
        chk("t4_no_ack", 32'(m_acks - s_ack), 32'd0);
        chk("t4_req_cycles", 32'(m_reqcyc - s_req), 32'd4);
        $display("WB  WR adr=00000050 aborted");
        t_delay = 0; t_rdata = 32'h55AA_0001;
        dbg_txn(1'b0, 32'h0000_0060, 32'h0, rd, err);
        chk("t4_dbg_rdata", rd, 32'h55AA_0001);
        chk("t4_dbg_err", 32'(err), 32'd0);

        // Reset pulse mid-transaction: everything cleared, no response
        t_delay = -1;
        s_ack = m_acks; s_to = m_tos;
        wbs_cyc = 1; wbs_stb = 1; wbs_we = 0; wbs_adr = 32'h0000_0070;
        step(); step();
        rst = 1; wbs_cyc = 0; wbs_stb = 0;
        step();
        chk("t5_req_cleared", 32'(mem_req_o), 32'd0);
        chk("t5_adr_cleared", mem_adr_o, 32'd0);
        rst = 0;
        repeat (T + 4) step();
        chk("t5_no_ack", 32'(m_acks - s_ack), 32'd0);
        chk("t5_no_timeout", 32'(m_tos - s_to), 32'd0);
        $display("RST mid-transaction");
        t_delay = 1; t_rdata = 32'h0BAD_CAFE;
        wb_txn(1'b0, 32'h0000_0080, 32'h0, rd);
        chk("t5_after_rdata", rd, 32'h0BAD_CAFE);

        // Ack on the watchdog's final cycle: normal completion
        t_delay = T - 1; t_rdata = 32'h600D_F00D;
        s_to = m_tos;
        wb_txn(1'b0, 32'h0000_0090, 32'h0, rd);
        step();
        chk("t6_rdata", rd, 32'h600D_F00D);
        chk("t6_no_timeout", 32'(m_tos - s_to), 32'd0);

        // Stray ack while idle is ignored
        s_ack = m_acks; s_done = m_dones;
        t_stray = 1;
        step();
        t_stray = 0;
        repeat (3) step();
        chk("t7_no_ack", 32'(m_acks - s_ack), 32'd0);
        chk("t7_no_done", 32'(m_dones - s_done), 32'd0);
        $display("ACK stray ack in idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL bench_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

endmodule
